// File: rtl/photodiode_pkg.sv
// Shared constants for the photodiode timing path (conditioner and delay stages).
package photodiode_pkg;

  localparam int unsigned N_PD_DEFAULT        = 5;
  localparam int unsigned FILT_BITS_DEFAULT   = 8;
  localparam int unsigned FILT_CYCLES_DEFAULT = 16;
  localparam int unsigned GLITCH_CNT_W        = 8;

  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

  // Saturating increment for the per-channel glitch counters.
  function automatic logic [GLITCH_CNT_W-1:0] glitch_sat_inc(
    input logic [GLITCH_CNT_W-1:0] value
  );
    return (value == GLITCH_CNT_MAX) ? value : value + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pd_filter_ch.sv
// One photodiode channel: 2-flop synchroniser, persistence filter, level
// register, edge pulses and (with PDC_GLITCH_CNT_EN) a saturating glitch count.
module pd_filter_ch
  import photodiode_pkg::*;
#(
  parameter int unsigned FILT_BITS   = FILT_BITS_DEFAULT,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    raw,
  input  logic                    err_clr,
  output logic                    level,
  output logic                    rise,
  output logic                    fall,
  output logic                    level_next_c,
  output logic                    rise_next_c,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam logic [FILT_BITS-1:0] CNT_LAST = FILT_BITS'(FILT_CYCLES - 1);

  logic                 s1;
  logic                 s2;
  logic [FILT_BITS-1:0] cnt;
  logic [FILT_BITS-1:0] cnt_next_c;
  logic                 accept_c;

  // Bring the asynchronous comparator line into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive cycles the synchronised input disagrees with the level.
  always_comb begin
    cnt_next_c = '0;
    accept_c   = 1'b0;
    if (s2 == level) begin
      cnt_next_c = '0;
    end else if (cnt == CNT_LAST) begin
      accept_c   = 1'b1;
    end else begin
      cnt_next_c = cnt + FILT_BITS'(1);
    end
  end

  // Next-cycle values exported so the order check can register in step with PD.
  assign level_next_c = accept_c ? s2 : level;
  assign rise_next_c  = accept_c & s2;

  // Level and edge pulses share one register stage so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_next_c;
      level <= level_next_c;
      rise  <= rise_next_c;
      fall  <= accept_c & ~s2;
    end
  end

`ifdef PDC_GLITCH_CNT_EN
  logic glitch_c;

  // A partial count abandoned because the input reverted is a glitch.
  assign glitch_c = (cnt != '0) && (s2 == level);

  // Saturating glitch count; a clear in the same cycle drops the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (err_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_c) begin
      glitch_cnt <= glitch_sat_inc(glitch_cnt);
    end
  end
`else
  logic unused_err_clr;

  // Glitch counting compiled out; the port stays for a stable interface.
  assign glitch_cnt     = '0;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: rtl/photodiode_conditioner.sv
// Photodiode front-end: per-channel synchronise/filter plus the out-of-order
// rise flag. Optional glitch counters are enabled by defining PDC_GLITCH_CNT_EN.
module photodiode_conditioner
  import photodiode_pkg::*;
#(
  parameter int unsigned N_PD        = N_PD_DEFAULT,
  parameter int unsigned FILT_BITS   = FILT_BITS_DEFAULT,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PD-1:0]              pd_raw,
  input  logic                         err_clr,
  output logic [N_PD-1:0]              PD,
  output logic [N_PD-1:0]              pd_rise,
  output logic [N_PD-1:0]              pd_fall,
  output logic                         order_err,
  output logic [GLITCH_CNT_W*N_PD-1:0] glitch_cnt
);

  logic [N_PD-1:0] pd_next_c;
  logic [N_PD-1:0] rise_next_c;
  logic            order_set_c;

  // Independent filter per photodiode channel.
  for (genvar k = 0; k < N_PD; k++) begin : g_ch
    pd_filter_ch #(
      .FILT_BITS   (FILT_BITS),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (pd_raw[k]),
      .err_clr      (err_clr),
      .level        (PD[k]),
      .rise         (pd_rise[k]),
      .fall         (pd_fall[k]),
      .level_next_c (pd_next_c[k]),
      .rise_next_c  (rise_next_c[k]),
      .glitch_cnt   (glitch_cnt[k*GLITCH_CNT_W +: GLITCH_CNT_W])
    );
  end

  // Channel k rising while channel k-1 will read low is out of order.
  assign order_set_c = |(rise_next_c[N_PD-1:1] & ~pd_next_c[N_PD-2:0]);

  // Sticky error flag; a new violation beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_err <= 1'b0;
    end else if (order_set_c) begin
      order_err <= 1'b1;
    end else if (err_clr) begin
      order_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_photodiode_conditioner.sv
// Self-checking bench for photodiode_conditioner against a window-based model.
module tb_photodiode_conditioner;

  localparam int unsigned NP = 5;
  localparam int unsigned F  = 16;
  localparam int unsigned GW = 8;
  localparam int unsigned VW = 3*NP + 1 + GW*NP;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    pd_raw;
  logic             err_clr;
  logic [NP-1:0]    PD;
  logic [NP-1:0]    pd_rise;
  logic [NP-1:0]    pd_fall;
  logic             order_err;
  logic [GW*NP-1:0] glitch_cnt;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  photodiode_conditioner #(
    .N_PD        (NP),
    .FILT_BITS   (8),
    .FILT_CYCLES (F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pd_raw     (pd_raw),
    .err_clr    (err_clr),
    .PD         (PD),
    .pd_rise    (pd_rise),
    .pd_fall    (pd_fall),
    .order_err  (order_err),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last F synchronised samples
  // all disagree with it; an abandoned disagreement is a glitch.
  logic [NP-1:0] raw_d1, raw_d2, m_prev_f;
  logic [NP-1:0] fin_q[$];
  logic [NP-1:0] m_pd, m_rise, m_fall;
  logic          m_err;
  logic [GW-1:0] m_gl [NP];

  task automatic model_step(input logic [NP-1:0] raw_now, input logic rst_now,
                            input logic clr_now);
    logic [NP-1:0] f, new_pd;
    logic all_diff, hit, set;
    if (rst_now) begin
      raw_d1 = '0; raw_d2 = '0; m_prev_f = '0; fin_q.delete();
      m_pd = '0; m_rise = '0; m_fall = '0; m_err = 1'b0;
      for (int k = 0; k < NP; k++) m_gl[k] = '0;
      return;
    end
    f = raw_d2;
    fin_q.push_back(f);
    if (fin_q.size() > F) void'(fin_q.pop_front());
    new_pd = m_pd; m_rise = '0; m_fall = '0;
    for (int k = 0; k < NP; k++) begin
      all_diff = (fin_q.size() == F);
      foreach (fin_q[i]) if (fin_q[i][k] == m_pd[k]) all_diff = 1'b0;
      if (all_diff) begin
        new_pd[k] = ~m_pd[k];
        m_rise[k] = new_pd[k];
        m_fall[k] = ~new_pd[k];
      end
      hit = (f[k] == m_pd[k]) && (m_prev_f[k] != m_pd[k]);
`ifdef PDC_GLITCH_CNT_EN
      if (clr_now) m_gl[k] = '0;
      else if (hit && m_gl[k] != 8'd255) m_gl[k] = m_gl[k] + 8'd1;
`else
      if (hit) m_gl[k] = '0;
`endif
    end
    set = 1'b0;
    for (int k = 1; k < NP; k++) if (m_rise[k] && !new_pd[k-1]) set = 1'b1;
    if (set) m_err = 1'b1;
    else if (clr_now) m_err = 1'b0;
    m_prev_f = f;
    m_pd = new_pd;
    raw_d2 = raw_d1;
    raw_d1 = raw_now;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [GW*NP-1:0] g;
    for (int k = 0; k < NP; k++) g[k*GW +: GW] = m_gl[k];
    return {m_pd, m_rise, m_fall, m_err, g};
  endfunction

  // Advance one clock; the model consumes the inputs held across the edge.
  task automatic tick();
    model_step(pd_raw, rst, err_clr);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [NP-1:0] raw_val);
    rst = 1'b1; pd_raw = raw_val; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pd_raw = 5'h1F; err_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== '0)
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt});
      else passes++;
    end
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
      if (i == 16 || i == 17) begin
        checks++;
        if (PD !== ((i == 17) ? 5'h1F : 5'h00))
          $display("FAIL reset_latency edge=%0d got=%h exp=%h", i + 1, PD,
                   (i == 17) ? 5'h1F : 5'h00);
        else passes++;
      end
    end
  endtask

  task automatic test_thermometer();
    logic [NP-1:0] steps [6];
    int rises [NP];
    logic [NP-1:0] prev;
    steps[0] = 5'h00; steps[1] = 5'h01; steps[2] = 5'h03;
    steps[3] = 5'h07; steps[4] = 5'h0F; steps[5] = 5'h1F;
    for (int k = 0; k < NP; k++) rises[k] = 0;
    do_reset(5'h00);
    prev = 5'h00;
    for (int s = 0; s < 6; s++) begin
      pd_raw = steps[s];
      for (int i = 0; i < 409; i++) begin
        tick();
        for (int k = 0; k < NP; k++) rises[k] += int'(pd_rise[k]);
        checks++;
        if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
          $display("FAIL thermo_model cyc=%0d got=%h exp=%h", cyc,
                   {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
        else passes++;
        if (i == 16 || i == 17) begin
          checks++;
          if (PD !== ((i == 17) ? steps[s] : prev))
            $display("FAIL thermo_latency step=%0d edge=%0d got=%h exp=%h", s, i + 1,
                     PD, (i == 17) ? steps[s] : prev);
          else passes++;
        end
      end
      prev = steps[s];
    end
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (rises[k] != 1) $display("FAIL thermo_rise_count ch=%0d got=%0d exp=1", k, rises[k]);
      else passes++;
    end
    checks++;
    if (order_err !== 1'b0) $display("FAIL thermo_order got=%b exp=0", order_err);
    else passes++;
  endtask

  task automatic test_glitch();
    int hi_cycles, nrise, nfall;
    logic [GW-1:0] exp_gl;
`ifdef PDC_GLITCH_CNT_EN
    exp_gl = 8'd1;
`else
    exp_gl = 8'd0;
`endif
    do_reset(5'h00);
    for (int i = 0; i < 60; i++) begin
      pd_raw = (i >= 5 && i < 20) ? 5'h04 : 5'h00;
      tick();
      checks++;
      if (PD[2] !== 1'b0 || {PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
        $display("FAIL glitch15 cyc=%0d got=%h exp=%h", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
    end
    checks++;
    if (glitch_cnt[23:16] !== exp_gl)
      $display("FAIL glitch15_count got=%0d exp=%0d", glitch_cnt[23:16], exp_gl);
    else passes++;
    hi_cycles = 0; nrise = 0; nfall = 0;
    for (int i = 0; i < 70; i++) begin
      pd_raw = (i >= 5 && i < 21) ? 5'h04 : 5'h00;
      tick();
      hi_cycles += int'(PD[2]);
      nrise += int'(pd_rise[2]);
      nfall += int'(pd_fall[2]);
      checks++;
      if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
        $display("FAIL glitch16 cyc=%0d got=%h exp=%h", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
    end
    checks++;
    if (hi_cycles != 16 || nrise != 1 || nfall != 1)
      $display("FAIL glitch16_pulse got=hi%0d/r%0d/f%0d exp=hi16/r1/f1",
               hi_cycles, nrise, nfall);
    else passes++;
  endtask

  task automatic test_order_err();
    do_reset(5'h00);
    pd_raw = 5'h08;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 16 || i == 17) begin
        checks++;
        if ({pd_rise[3], order_err} !== ((i == 17) ? 2'b11 : 2'b00))
          $display("FAIL order_set edge=%0d got=%b exp=%b", i + 1, {pd_rise[3], order_err},
                   (i == 17) ? 2'b11 : 2'b00);
        else passes++;
      end
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (order_err !== 1'b0) $display("FAIL order_clear got=%b exp=0", order_err);
    else passes++;
    pd_raw = 5'h09;
    for (int i = 0; i < 25; i++) tick();
    pd_raw = 5'h0F;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec() || order_err !== 1'b0)
        $display("FAIL order_simul cyc=%0d got=%h exp=%h", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
    end
    pd_raw = 5'h00;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (order_err !== 1'b0) $display("FAIL order_pre_coincident got=%b exp=0", order_err);
    else passes++;
    pd_raw = 5'h10;
    for (int i = 0; i < 25; i++) begin
      err_clr = (i == 17);
      tick();
      if (i == 17) begin
        checks++;
        if ({pd_rise[4], order_err} !== 2'b11)
          $display("FAIL order_clr_coincident got=%b exp=11", {pd_rise[4], order_err});
        else passes++;
      end
    end
    err_clr = 1'b0;
  endtask

  task automatic test_glitch_sat();
    logic [GW-1:0] exp_gl;
`ifdef PDC_GLITCH_CNT_EN
    exp_gl = 8'd255;
`else
    exp_gl = 8'd0;
`endif
    do_reset(5'h00);
    for (int i = 0; i < 300; i++) begin
      pd_raw = 5'h01; tick();
      pd_raw = 5'h00; tick();
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (glitch_cnt[7:0] !== exp_gl || {PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
      $display("FAIL glitch_sat got=%0d exp=%0d", glitch_cnt[7:0], exp_gl);
    else passes++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (glitch_cnt !== '0) $display("FAIL glitch_clear got=%h exp=0", glitch_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset(5'h00);
    pd_raw = 5'h10;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (PD[4] !== (i >= 17) || {PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
        $display("FAIL reset_mid edge=%0d got=%h exp=%h", i + 1,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_random();
    int remain;
    do_reset(5'h00);
    remain = 0;
    for (int i = 0; i < 4000; i++) begin
      if (remain == 0) begin
        pd_raw = NP'($urandom);
        remain = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(10, 40);
      end
      remain--;
      err_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      checks++;
      if ({PD, pd_rise, pd_fall, order_err, glitch_cnt} !== exp_vec())
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                 {PD, pd_rise, pd_fall, order_err, glitch_cnt}, exp_vec());
      else passes++;
    end
    rst = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pd_raw = '0; err_clr = 1'b0;
    test_reset();
    test_thermometer();
    test_glitch();
    test_order_err();
    test_glitch_sat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
